fetcher: RTL
============

# fetcher

Instruction fetch stage of the multi-cycle RV32IM core, sitting directly upstream of the decoder. On an `enabled` pulse from the core controller it latches the next PC, reads one 32-bit word over an AXI4-Lite-style read channel, and presents `pc` / `instr_raw` with a one-cycle `completed` pulse. Misaligned PCs and bus error responses are reported as fetch exceptions instead of issuing or using the bus word.

## Interface
- `NOP_INSTR`, default 32'h00000013, word driven on `instr_raw` at reset and on any fetch exception.
- `clk`  in  1  clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `enabled`  in  1  start fetch; sampled only in IDLE.
- `completed`  out  1  one-cycle pulse: `pc`, `instr_raw` and exception flags are valid.
- `pc_in`  in  32  address to fetch; sampled with `enabled`.
- `pc`  out  32  latched fetch address.
- `instr_raw`  out  32  fetched instruction word, or `NOP_INSTR`.
- `instr_misaligned`  out  1  `pc_in[1:0]` != 0.
- `access_fault`  out  1  bus returned `mem_rresp` != 2'b00.
- `mem_araddr`  out  32  read address.
- `mem_arvalid`  out  1  address valid.
- `mem_arready`  in  1  address accepted.
- `mem_rdata`  in  32  read data.
- `mem_rresp`  in  2  read response; 00 OKAY, anything else is an error.
- `mem_rvalid`  in  1  read data valid.
- `mem_rready`  out  1  fetcher ready for read data.

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE: when `enabled`=1, latch `pc` <= `pc_in` and clear both exception flags.
  - If `pc_in[1:0]` != 0: set `instr_misaligned`=1 and `instr_raw`=`NOP_INSTR`, go to DONE. No bus activity.
  - Otherwise: drive `mem_araddr`=`pc_in`, set `mem_arvalid`=1, go to ADDR.
- ADDR: hold `mem_arvalid` and `mem_araddr` stable until a clock edge with `mem_arready`=1. At that edge drop `mem_arvalid`, set `mem_rready`=1, go to DATA.
- DATA: on a clock edge with `mem_rvalid`=1:
  - drop `mem_rready`;
  - if `mem_rresp`==00, `instr_raw` <= `mem_rdata`;
  - else `instr_raw` <= `NOP_INSTR` and `access_fault` <= 1;
  - go to DONE.
- DONE: `completed`=1 for exactly this one cycle, then return to IDLE.
- `enabled` is ignored in ADDR, DATA and DONE. It is never queued.
- `pc`, `instr_raw` and the exception flags hold their values from the DONE cycle until the next accepted `enabled`. The decoder may sample them at any time after `completed`.
- `mem_rdata` received outside DATA is ignored.
- At most one exception flag is ever set per fetch.

## Timing
- Reset (`rstn`=0 at a clock edge), from any state including mid-transaction:
  - state=IDLE;
  - `completed`, `mem_arvalid`, `mem_rready`, `instr_misaligned`, `access_fault` = 0;
  - `pc`, `mem_araddr` = 0;
  - `instr_raw` = `NOP_INSTR`.
- Abandoning an outstanding bus transaction on reset is legal: the memory system is reset by the same `rstn`.
- All outputs are registered; no combinational path runs from any input to any output.
- Let edge E be the edge that samples `enabled`:
  - `mem_arvalid` is high from E.
  - With `mem_arready` already high, the address handshake occurs at E+1 and `mem_rready` is high from E+1.
  - With `mem_rvalid` high at E+2, `completed` is high in the cycle after E+2. Best-case latency is 3 cycles.
  - Each cycle of `mem_arready` or `mem_rvalid` wait adds one cycle.
- Misaligned fetch: `completed` is high in the cycle after E+1 (2 cycles).
- The earliest next accepted `enabled` is at the edge ending the DONE cycle + 1, i.e. while back in IDLE.

## Test plan
- Aligned fetch, zero-wait memory:
  - stimulus: `pc_in`=0x00000100, word 0x00A00093;
  - response: `mem_araddr`=0x100, `completed` pulse 3 cycles after `enabled`, `instr_raw`=0x00A00093, `pc`=0x100, both flags 0.
- Wait states:
  - stimulus: `mem_arready` delayed 2 cycles and `mem_rvalid` delayed 3 cycles;
  - response: `mem_arvalid`/`mem_araddr` stable throughout, `completed` 8 cycles after `enabled`, exactly one pulse.
- Misaligned:
  - stimulus: `pc_in`=0x00000102;
  - response: no `mem_arvalid`, `completed` after 2 cycles, `instr_misaligned`=1, `instr_raw`=0x00000013, `pc`=0x102.
- Bus error:
  - stimulus: `mem_rresp`=2'b10 with `mem_rdata`=0xDEADBEEF;
  - response: `access_fault`=1, `instr_raw`=0x00000013.
- `enabled` held high during fetch:
  - stimulus: hold `enabled` high through ADDR and DATA;
  - response: a single bus transaction, and a new fetch starts only from IDLE.
- Reset in DATA:
  - stimulus: `rstn`=0 while in DATA;
  - response: at the next edge all outputs take their reset values.
  - follow-up: a fresh fetch of 0x00000004 then completes normally.

Source files
------------

// File: rtl/fetcher.sv
// Instruction fetch stage: latches a PC on request, reads one word over an
// AXI4-Lite-style read channel and hands pc/instr_raw to the decoder with a
// one-cycle completed pulse. Misaligned PCs and bus errors become exceptions
// and deliver NOP_INSTR instead of a bus word.
module fetcher #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        enabled,
   output logic        completed,
   input  logic [31:0] pc_in,
   output logic [31:0] pc,
   output logic [31:0] instr_raw,
   output logic        instr_misaligned,
   output logic        access_fault,
   output logic [31:0] mem_araddr,
   output logic        mem_arvalid,
   input  logic        mem_arready,
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  mem_rresp,
   input  logic        mem_rvalid,
   output logic        mem_rready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_q,     state_d;
   logic [31:0] pc_q,        pc_d;
   logic [31:0] instr_q,     instr_d;
   logic        mis_q,       mis_d;
   logic        fault_q,     fault_d;
   logic [31:0] araddr_q,    araddr_d;
   logic        arvalid_q,   arvalid_d;
   logic        rready_q,    rready_d;
   logic        completed_q, completed_d;

   // Next-state and next-output logic of the fetch sequencer.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      mis_d       = mis_q;
      fault_d     = fault_q;
      araddr_d    = araddr_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      completed_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (enabled) begin
               pc_d    = pc_in;
               mis_d   = 1'b0;
               fault_d = 1'b0;
               // A misaligned fetch still passes through ADDR (without
               // raising arvalid) so it reports after two cycles.
               if (pc_in[1:0] != 2'b00) begin
                  mis_d   = 1'b1;
                  instr_d = NOP_INSTR;
                  state_d = ADDR;
               end else begin
                  araddr_d  = pc_in;
                  arvalid_d = 1'b1;
                  state_d   = ADDR;
               end
            end else begin
               state_d = IDLE;
            end
         end

         ADDR: begin
            if (mis_q) begin
               state_d     = DONE;
               completed_d = 1'b1;
            end else if (mem_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = DATA;
            end else begin
               state_d = ADDR;
            end
         end

         DATA: begin
            if (mem_rvalid) begin
               rready_d    = 1'b0;
               state_d     = DONE;
               completed_d = 1'b1;
               if (mem_rresp == 2'b00) begin
                  instr_d = mem_rdata;
               end else begin
                  instr_d = NOP_INSTR;
                  fault_d = 1'b1;
               end
            end else begin
               state_d = DATA;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d   = IDLE;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         pc_q        <= 32'h0000_0000;
         instr_q     <= NOP_INSTR;
         mis_q       <= 1'b0;
         fault_q     <= 1'b0;
         araddr_q    <= 32'h0000_0000;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         completed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         mis_q       <= mis_d;
         fault_q     <= fault_d;
         araddr_q    <= araddr_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         completed_q <= completed_d;
      end
   end

   assign completed        = completed_q;
   assign pc               = pc_q;
   assign instr_raw        = instr_q;
   assign instr_misaligned = mis_q;
   assign access_fault     = fault_q;
   assign mem_araddr       = araddr_q;
   assign mem_arvalid      = arvalid_q;
   assign mem_rready       = rready_q;

endmodule
